// File: rtl/norm_pipe_param_pkg.sv
// norm_pipe_param_pkg
//   Shared defaults for the parametrised normaliser pipeline.
//   DEF_W     : width of the count / max inputs
//   DEF_OB    : output bits, one restoring-division stage per bit
//   DEF_TW    : width of the tag carried alongside each sample
//   DEF_ROUND : 0 = truncate, 1 = round half up in the final stage
package norm_pipe_param_pkg;

    localparam int DEF_W     = 20;
    localparam int DEF_OB    = 8;
    localparam int DEF_TW    = 4;
    localparam int DEF_ROUND = 0;

endpackage

// File: rtl/norm_bit_stage.sv
// norm_bit_stage
//   One registered restoring-division step of the normaliser pipeline.
//   Shifts the partial remainder left, subtracts max when it fits and drops
//   the resulting quotient bit into position OB-idx of q (MSB first).
//   The stage with idx == OB is the last one: its register is the pipeline
//   output register, so it also applies the sat/dz override and optional
//   rounding before capture.
//   Ports:
//     clk, rst, en        : clock, async active-high reset, advance enable
//     in_*                : previous stage contents (valid, r, q, max, tag, sat, dz)
//     out_*               : this stage's registered contents
module norm_bit_stage #(
    parameter int W     = 20,
    parameter int OB    = 8,
    parameter int TW    = 4,
    parameter int idx   = 1,
    parameter int ROUND = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [W:0]    in_r,
    input  logic [OB-1:0] in_q,
    input  logic [W-1:0]  in_max,
    input  logic [TW-1:0] in_tag,
    input  logic          in_sat,
    input  logic          in_dz,
    output logic          out_valid,
    output logic [W:0]    out_r,
    output logic [OB-1:0] out_q,
    output logic [W-1:0]  out_max,
    output logic [TW-1:0] out_tag,
    output logic          out_sat,
    output logic          out_dz
);
    localparam bit LAST = (idx == OB);

    logic [W+1:0]  r2;
    logic [W+1:0]  max_ext;
    logic          ge;
    logic [W:0]    r_step;
    logic [OB-1:0] q_step;
    logic [OB-1:0] q_fin;

    logic          valid_d, valid_q;
    logic [W:0]    r_d, r_q;
    logic [OB-1:0] q_d, q_q;
    logic [W-1:0]  max_d, max_q;
    logic [TW-1:0] tag_d, tag_q;
    logic          sat_d, sat_q;
    logic          dz_d, dz_q;

    always_comb begin
        max_ext = {2'b00, in_max};
        r2      = {in_r, 1'b0};
        ge      = (r2 >= max_ext);
        // r < max keeps the difference inside W+1 bits; for sat/dz samples
        // the remainder is meaningless and is discarded by the override.
        r_step  = ge ? (W+1)'(r2 - max_ext) : r2[W:0];
        q_step  = in_q;
        q_step[OB-idx] = ge;

        q_fin = q_step;
        if (LAST) begin
            if (in_sat || in_dz) begin
                q_fin = '1;
            end else if ((ROUND != 0) && ({r_step, 1'b0} >= max_ext) && !(&q_step)) begin
                // Guard bit set: round up, but never wrap past all ones.
                q_fin = q_step + OB'(1);
            end
        end

        valid_d = valid_q;
        r_d     = r_q;
        q_d     = q_q;
        max_d   = max_q;
        tag_d   = tag_q;
        sat_d   = sat_q;
        dz_d    = dz_q;
        if (en) begin
            valid_d = in_valid;
            r_d     = r_step;
            q_d     = q_fin;
            max_d   = in_max;
            tag_d   = in_tag;
            sat_d   = in_sat;
            dz_d    = in_dz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            r_q     <= '0;
            q_q     <= '0;
            max_q   <= '0;
            tag_q   <= '0;
            sat_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            r_q     <= r_d;
            q_q     <= q_d;
            max_q   <= max_d;
            tag_q   <= tag_d;
            sat_q   <= sat_d;
            dz_q    <= dz_d;
        end
    end

    assign out_valid = valid_q;
    assign out_r     = r_q;
    assign out_q     = q_q;
    assign out_max   = max_q;
    assign out_tag   = tag_q;
    assign out_sat   = sat_q;
    assign out_dz    = dz_q;

endmodule

// File: rtl/norm_pipe_param.sv
// norm_pipe_param
//   Fully pipelined normaliser: out_norm = floor(count * 2^OB / max), with
//   optional round-half-up. One sample per enabled cycle, tag carried along.
//   Input register (stage 0) followed by OB restoring bit stages; the last
//   bit stage doubles as the output register, giving OB+1 enabled edges of
//   latency.
//   Ports:
//     MHz10, rst      : clock (rising edge), async active-high reset
//     en              : pipeline advance; low freezes every register
//     in_valid, count, max, in_tag : sample input, sampled when en=1
//     out_valid, out_norm, out_tag : result (out_valid holds while en=0)
//     out_sat         : count >= max with max != 0, out_norm all ones
//     out_dz          : max == 0, out_norm all ones
//     busy            : any stage holds a valid sample
module norm_pipe_param
    import norm_pipe_param_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int OB    = DEF_OB,
    parameter int TW    = DEF_TW,
    parameter int ROUND = DEF_ROUND
) (
    input  logic          MHz10,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [W-1:0]  count,
    input  logic [W-1:0]  max,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [OB-1:0] out_norm,
    output logic [TW-1:0] out_tag,
    output logic          out_sat,
    output logic          out_dz,
    output logic          busy
);
    // Stage 0 (input register)
    logic          s0_valid_d, s0_valid_q;
    logic [W:0]    s0_r_d, s0_r_q;
    logic [W-1:0]  s0_max_d, s0_max_q;
    logic [TW-1:0] s0_tag_d, s0_tag_q;
    logic          s0_sat_d, s0_sat_q;
    logic          s0_dz_d, s0_dz_q;

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_r_d     = s0_r_q;
        s0_max_d   = s0_max_q;
        s0_tag_d   = s0_tag_q;
        s0_sat_d   = s0_sat_q;
        s0_dz_d    = s0_dz_q;
        if (en) begin
            s0_valid_d = in_valid;
            s0_r_d     = {1'b0, count};
            s0_max_d   = max;
            s0_tag_d   = in_tag;
            s0_dz_d    = (max == '0);
            s0_sat_d   = (max != '0) && (count >= max);
        end
    end

    always_ff @(posedge MHz10 or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_r_q     <= '0;
            s0_max_q   <= '0;
            s0_tag_q   <= '0;
            s0_sat_q   <= 1'b0;
            s0_dz_q    <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_r_q     <= s0_r_d;
            s0_max_q   <= s0_max_d;
            s0_tag_q   <= s0_tag_d;
            s0_sat_q   <= s0_sat_d;
            s0_dz_q    <= s0_dz_d;
        end
    end

    // Inter-stage buses: index 0 is the input register, index OB the output.
    logic [OB:0]          v_a;
    logic [OB:0][W:0]     r_a;
    logic [OB:0][OB-1:0]  q_a;
    logic [OB:0][W-1:0]   max_a;
    logic [OB:0][TW-1:0]  tag_a;
    logic [OB:0]          sat_a;
    logic [OB:0]          dz_a;

    assign v_a[0]   = s0_valid_q;
    assign r_a[0]   = s0_r_q;
    assign q_a[0]   = '0;
    assign max_a[0] = s0_max_q;
    assign tag_a[0] = s0_tag_q;
    assign sat_a[0] = s0_sat_q;
    assign dz_a[0]  = s0_dz_q;

    for (genvar gi = 1; gi <= OB; gi++) begin : g_stage
        norm_bit_stage #(
            .W     (W),
            .OB    (OB),
            .TW    (TW),
            .idx   (gi),
            .ROUND (ROUND)
        ) u_stage (
            .clk       (MHz10),
            .rst       (rst),
            .en        (en),
            .in_valid  (v_a[gi-1]),
            .in_r      (r_a[gi-1]),
            .in_q      (q_a[gi-1]),
            .in_max    (max_a[gi-1]),
            .in_tag    (tag_a[gi-1]),
            .in_sat    (sat_a[gi-1]),
            .in_dz     (dz_a[gi-1]),
            .out_valid (v_a[gi]),
            .out_r     (r_a[gi]),
            .out_q     (q_a[gi]),
            .out_max   (max_a[gi]),
            .out_tag   (tag_a[gi]),
            .out_sat   (sat_a[gi]),
            .out_dz    (dz_a[gi])
        );
    end

    // The final remainder and divisor are consumed inside the last stage.
    logic tail_unused;
    assign tail_unused = ^{r_a[OB], max_a[OB]};

    assign out_valid = v_a[OB];
    assign out_norm  = q_a[OB];
    assign out_tag   = tag_a[OB];
    assign out_sat   = sat_a[OB];
    assign out_dz    = dz_a[OB];
    assign busy      = |v_a;

endmodule

// File: tb/tb_norm_pipe_param.sv
module tb_norm_pipe_param;
    localparam int W  = 20;
    localparam int OB = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  count = '0;
    logic [W-1:0]  max_v = '0;
    logic [TW-1:0] in_tag = '0;

    logic          ov_t, sat_t, dz_t, busy_t;
    logic [OB-1:0] norm_t;
    logic [TW-1:0] tag_t;
    logic          ov_r, sat_r, dz_r, busy_r;
    logic [OB-1:0] norm_r;
    logic [TW-1:0] tag_r;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    norm_pipe_param #(.W(W), .OB(OB), .TW(TW), .ROUND(0)) dut_t (
        .MHz10(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .count(count), .max(max_v), .in_tag(in_tag),
        .out_valid(ov_t), .out_norm(norm_t), .out_tag(tag_t),
        .out_sat(sat_t), .out_dz(dz_t), .busy(busy_t)
    );

    norm_pipe_param #(.W(W), .OB(OB), .TW(TW), .ROUND(1)) dut_r (
        .MHz10(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .count(count), .max(max_v), .in_tag(in_tag),
        .out_valid(ov_r), .out_norm(norm_r), .out_tag(tag_r),
        .out_sat(sat_r), .out_dz(dz_r), .busy(busy_r)
    );

    typedef struct {
        logic [W-1:0]  c;
        logic [W-1:0]  m;
        logic [TW-1:0] tag;
        logic [OB-1:0] exp_t;
        logic [OB-1:0] exp_r;
        logic          sat;
        logic          dz;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer division of count*2^OB by max.
    function automatic logic [OB-1:0] ref_norm(input logic [W-1:0] c, input logic [W-1:0] m,
                                               input bit rnd);
        longint unsigned num, q, rem;
        if (m == '0 || c >= m) return '1;
        num = 64'(c) << OB;
        q   = num / 64'(m);
        rem = num % 64'(m);
        if (rnd && (2 * rem >= 64'(m)) && q < 64'((1 << OB) - 1)) q++;
        return OB'(q);
    endfunction

    task automatic run_one(input int i);
        vec_t v;
        int edges;
        bit found;
        v = tbl[i];
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; count = v.c; max_v = v.m; in_tag = v.tag;
        edges = 0; found = 1'b0;
        repeat (20) begin
            @(posedge clk); edges++; #1;
            if (edges == 1) in_valid = 1'b0;
            if (ov_t) begin found = 1'b1; break; end
        end
        chk("lat", edges, OB + 1);
        chk("found", found, 1);
        chk("ov_r", ov_r, 1);
        chk("norm_t", norm_t, v.exp_t);
        chk("norm_r", norm_r, v.exp_r);
        chk("tag_t", tag_t, v.tag);
        chk("tag_r", tag_r, v.tag);
        chk("sat_t", sat_t, v.sat);
        chk("sat_r", sat_r, v.sat);
        chk("dz_t", dz_t, v.dz);
        chk("dz_r", dz_r, v.dz);
        $display("vec %0d: count=%0d max=%0d tag=%0d -> norm_t=%0d norm_r=%0d sat=%0b dz=%0b lat=%0d",
                 i, v.c, v.m, v.tag, norm_t, norm_r, sat_t, dz_t, edges);
        @(posedge clk); #1;
        chk("pulse", ov_t, 0);
    endtask

    task automatic run_stream(input bit stall);
        logic [W-1:0] sc [16];
        logic [W-1:0] sm [16];
        int acc_edge [16];
        bit en_hist [128];
        int sent, got, prev_out, e, dis;
        sent = 0; got = 0; prev_out = -1; e = 0;
        for (int k = 0; k < 16; k++) begin
            sm[k] = W'($urandom_range(1, (1 << W) - 1));
            sc[k] = W'($urandom_range(0, int'(sm[k]) - 1));
        end
        while (got < 16 && e < 100) begin
            @(negedge clk);
            en = stall ? !((e >= 3 && e <= 5) || (e >= 14 && e <= 16)) : 1'b1;
            en_hist[e] = en;
            if (sent < 16) begin
                in_valid = 1'b1; count = sc[sent]; max_v = sm[sent]; in_tag = TW'(sent);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (en && in_valid) begin acc_edge[sent] = e; sent++; end
            if (sent > 0 && got < 16) chk("busy", busy_t, 1);
            if (en) begin
                if (ov_t) begin
                    chk("early", got < sent, 1);
                    dis = 0;
                    for (int j = acc_edge[got] + 1; j < e; j++) if (!en_hist[j]) dis++;
                    chk("s_lat", e - acc_edge[got], OB + dis);
                    chk("s_norm_t", norm_t, ref_norm(sc[got], sm[got], 1'b0));
                    chk("s_norm_r", norm_r, ref_norm(sc[got], sm[got], 1'b1));
                    chk("s_tag", tag_t, got);
                    chk("s_ov_r", ov_r, 1);
                    chk("s_sat", sat_t, 0);
                    $display("stream%0d out %0d: count=%0d max=%0d norm_t=%0d norm_r=%0d lat=%0d",
                             stall, got, sc[got], sm[got], norm_t, norm_r, e - acc_edge[got]);
                    prev_out = got;
                    got++;
                end else begin
                    prev_out = -1;
                end
            end else begin
                chk("frz_valid", ov_t, prev_out >= 0);
                if (prev_out >= 0) begin
                    chk("frz_norm", norm_t, ref_norm(sc[prev_out], sm[prev_out], 1'b0));
                    chk("frz_tag", tag_t, prev_out);
                end
            end
            e++;
        end
        chk("s_count", got, 16);
        @(negedge clk);
        in_valid = 1'b0; en = 1'b1;
    endtask

    initial begin
        int spurious;
        tbl[0]  = '{20'd5,       20'd10,      4'd3,  8'd128, 8'd128, 1'b0, 1'b0};
        tbl[1]  = '{20'd10,      20'd10,      4'd1,  8'd255, 8'd255, 1'b1, 1'b0};
        tbl[2]  = '{20'd7,       20'd0,       4'd2,  8'd255, 8'd255, 1'b0, 1'b1};
        tbl[3]  = '{20'd2,       20'd3,       4'd4,  8'd170, 8'd171, 1'b0, 1'b0};
        tbl[4]  = '{20'd1,       20'd3,       4'd5,  8'd85,  8'd85,  1'b0, 1'b0};
        tbl[5]  = '{20'd1023,    20'd1024,    4'd6,  8'd255, 8'd255, 1'b0, 1'b0};
        tbl[6]  = '{20'd3,       20'd7,       4'd7,  8'd109, 8'd110, 1'b0, 1'b0};
        tbl[7]  = '{20'd0,       20'd1000,    4'd8,  8'd0,   8'd0,   1'b0, 1'b0};
        tbl[8]  = '{20'd1,       20'd2,       4'd9,  8'd128, 8'd128, 1'b0, 1'b0};
        tbl[9]  = '{20'd12,      20'd7,       4'd10, 8'd255, 8'd255, 1'b1, 1'b0};
        tbl[10] = '{20'd999999,  20'd1000000, 4'd11, 8'd255, 8'd255, 1'b0, 1'b0};
        tbl[11] = '{20'd1048575, 20'd1048575, 4'd12, 8'd255, 8'd255, 1'b1, 1'b0};

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        chk("rst_ov", ov_t, 0);
        chk("rst_norm", norm_t, 0);
        chk("rst_tag", tag_t, 0);
        chk("rst_sat", sat_t, 0);
        chk("rst_dz", dz_t, 0);
        chk("rst_busy", busy_t, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_one(i);

        run_stream(1'b0);
        run_stream(1'b1);

        // Reset with 5 samples in flight
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; count = W'(k + 1); max_v = 20'd10; in_tag = TW'(k + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("inflight_busy", busy_t, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy_t", busy_t, 0);
        chk("arst_busy_r", busy_r, 0);
        chk("arst_ov", ov_t, 0);
        chk("arst_norm", norm_t, 0);
        chk("arst_tag", tag_t, 0);
        $display("reset with samples in flight: busy=%0b out_valid=%0b", busy_t, ov_t);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov_t || ov_r) spurious++;
        end
        chk("no_stale", spurious, 0);
        run_one(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
